// File: rtl/accumulator_buffer.sv
// accumulator_buffer: DEPTH-row, 2-column accumulator that collects one tile of aligned rows, then drains it over valid/ready.
// Define ACCUM_BUFFER_SAT_EN for saturating accumulation and the sticky sat_flag output.
`timescale 1ns/1ps
module accumulator_buffer #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [15:0]                  in_col0,
  input  logic [15:0]                  in_col1,
  input  logic                         start,
  input  logic                         acc_mode,
  input  logic [$clog2(DEPTH+1)-1:0]   rows,
  output logic                         busy,
  output logic                         done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_col0,
  output logic [ACC_W-1:0]             out_col1,
  output logic                         drop_err
`ifdef ACCUM_BUFFER_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, last_ptr, last_ptr_d;
  logic               mode;
  logic [ACC_W-1:0]   mem0 [DEPTH];
  logic [ACC_W-1:0]   mem1 [DEPTH];
  logic [CNT_W-1:0]   rows_eff;
  logic [ACC_W-1:0]   ext0, ext1, wdata0, wdata1;
  logic               start_ok, wr_en, wr_last, xfer, rd_last;

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_col0  = out_valid ? mem0[rd_ptr] : '0;
  assign out_col1  = out_valid ? mem1[rd_ptr] : '0;

  assign start_ok = (state == IDLE) && start;
  assign wr_en    = (state == FILL) && valid_in;
  assign wr_last  = wr_en && (wr_ptr == last_ptr);
  assign xfer     = out_valid && out_ready;
  assign rd_last  = xfer && (rd_ptr == last_ptr);

  // A row count of 0 or beyond DEPTH means a full tile; keep N-1 so pointers compare directly.
  assign rows_eff   = (rows == '0 || rows > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : rows;
  assign last_ptr_d = PTR_W'(rows_eff - CNT_W'(1));

  assign ext0 = {{(ACC_W-16){in_col0[15]}}, in_col0};
  assign ext1 = {{(ACC_W-16){in_col1[15]}}, in_col1};

`ifdef ACCUM_BUFFER_SAT_EN
  logic sat0, sat1;

  // Returns {overflow, clamped sum}; overflow when both operands share a sign the sum does not.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    logic             ovf;
    s   = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    if (ovf) s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return {ovf, s};
  endfunction

  always_comb begin
    {sat0, wdata0} = mode ? sat_add(mem0[wr_ptr], ext0) : {1'b0, ext0};
    {sat1, wdata1} = mode ? sat_add(mem1[wr_ptr], ext1) : {1'b0, ext1};
  end
`else
  always_comb begin
    wdata0 = mode ? mem0[wr_ptr] + ext0 : ext0;
    wdata1 = mode ? mem1[wr_ptr] + ext1 : ext1;
  end
`endif

  // NOTE: next-state starts from the current state so every path assigns state_d and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start)   state_d = FILL;
      FILL:    if (wr_last) state_d = DRAIN;
      DRAIN:   if (rd_last) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_ptr <= '0;
      mode     <= 1'b0;
      done     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      done     <= rd_last;
      // A drop on the same edge as an accepted start still leaves the flag set.
      drop_err <= (start_ok ? 1'b0 : drop_err) | (valid_in && state != FILL);
      if (start_ok) begin
        mode     <= acc_mode;
        last_ptr <= last_ptr_d;
        wr_ptr   <= '0;
      end
      if (wr_en)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (wr_last) rd_ptr <= '0;
      if (xfer)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

`ifdef ACCUM_BUFFER_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_flag <= 1'b0;
    else       sat_flag <= (start_ok ? 1'b0 : sat_flag) | (wr_en && (sat0 || sat1));
  end
`endif

  // NOTE: the accumulator array is reset on purpose; acc_mode tiles after reset must add onto zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else if (wr_en) begin
      mem0[wr_ptr] <= wdata0;
      mem1[wr_ptr] <= wdata1;
    end
  end

endmodule

// File: tb/tb_accumulator_buffer.sv
// Self-checking bench for accumulator_buffer: directed tiles plus randomized tiles against an array model.
`timescale 1ns/1ps
module tb_accumulator_buffer;

  localparam int DEPTH = 8;
  localparam int ACC_W = 32;
  localparam int SW    = 17;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, valid_in, start, acc_mode, out_ready;
  logic [15:0]      in_col0, in_col1;
  logic [CNT_W-1:0] rows;
  logic             busy, done, out_valid, drop_err;
  logic [ACC_W-1:0] out_col0, out_col1;
  logic             s_busy, s_done, s_out_valid, s_drop_err;
  logic [SW-1:0]    s_out_col0, s_out_col1;
`ifdef ACCUM_BUFFER_SAT_EN
  logic             sat_flag, s_sat_flag;
`endif

  always #5 clk = ~clk;

  accumulator_buffer #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_col0(in_col0), .in_col1(in_col1),
    .start(start), .acc_mode(acc_mode), .rows(rows), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_col0(out_col0), .out_col1(out_col1),
    .drop_err(drop_err)
`ifdef ACCUM_BUFFER_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  // Narrow instance sharing all stimulus; used to reach the accumulator's overflow boundary cheaply.
  accumulator_buffer #(.DEPTH(DEPTH), .ACC_W(SW)) dut_s (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_col0(in_col0), .in_col1(in_col1),
    .start(start), .acc_mode(acc_mode), .rows(rows), .busy(s_busy), .done(s_done),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_col0(s_out_col0), .out_col1(s_out_col1),
    .drop_err(s_drop_err)
`ifdef ACCUM_BUFFER_SAT_EN
    , .sat_flag(s_sat_flag)
`endif
  );

  logic [31:0] m0 [DEPTH];
  logic [31:0] m1 [DEPTH];
  logic [15:0] st0 [DEPTH];
  logic [15:0] st1 [DEPTH];
  int          errors = 0;
  int          checks = 0;
  int          tile_n;
  bit          cur_mode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_upd(input logic [31:0] old, input logic [15:0] d, input bit mode);
    longint e, s;
    e = longint'($signed(d));
    if (!mode) return e[31:0];
    s = longint'($signed(old)) + e;
`ifdef ACCUM_BUFFER_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < DEPTH; i++) begin
      st0[i] = 16'($urandom);
      st1[i] = 16'($urandom);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic begin_tile(input int r, input bit mode, input bit with_valid);
    start    = 1'b1;
    rows     = CNT_W'(r);
    acc_mode = mode;
    valid_in = with_valid;
    in_col0  = 16'h5A5A;
    in_col1  = 16'hA5A5;
    @(negedge clk);
    start    = 1'b0;
    valid_in = 1'b0;
    tile_n   = (r == 0 || r > DEPTH) ? DEPTH : r;
    cur_mode = mode;
    check("busy_after_start", 64'(busy), 64'd1);
    check("drop_after_start", 64'(drop_err), 64'(with_valid));
  endtask

  task automatic fill(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      check("fill_no_valid", 64'(out_valid), 64'd0);
      valid_in = 1'b1;
      in_col0  = st0[i];
      in_col1  = st1[i];
      m0[i]    = model_upd(m0[i], st0[i], cur_mode);
      m1[i]    = model_upd(m1[i], st1[i], cur_mode);
      @(negedge clk);
      valid_in = 1'b0;
    end
    check("fill_end_valid", 64'(out_valid), 64'(n == tile_n));
  endtask

  task automatic drain(input int n, input bit rnd, input int stall_row, input int stall_n, output int cycles);
    int row = 0;
    int stalled = 0;
    cycles = 0;
    while (row < n && cycles < 200) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_done_low", 64'(done), 64'd0);
      check("col0", 64'(out_col0), 64'(m0[row]));
      check("col1", 64'(out_col1), 64'(m1[row]));
      if (row == stall_row && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (out_ready) row++;
      cycles++;
    end
    out_ready = 1'b0;
    check("drain_timeout", 64'(row), 64'(n));
    check("done_pulse", 64'(done), 64'd1);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_once", 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int r;
    reset = 1'b1; valid_in = 1'b0; start = 1'b0; acc_mode = 1'b0; out_ready = 1'b0;
    in_col0 = '0; in_col1 = '0; rows = '0;
    model_clear();
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_drop_err", 64'(drop_err), 64'd0);
    check("rst_col0", 64'(out_col0), 64'd0);
    check("rst_col1", 64'(out_col1), 64'd0);
`ifdef ACCUM_BUFFER_SAT_EN
    check("rst_sat_flag", 64'(sat_flag), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Overwrite tile
    st0[0] = 16'd5;      st1[0] = 16'hFFFE;
    st0[1] = 16'd7;      st1[1] = 16'd4;
    st0[2] = 16'hFFFF;   st1[2] = 16'd0;
    begin_tile(3, 1'b0, 1'b0);
    fill(3, 1'b0);
    check("ovw_row0_col1", 64'(out_col1), 64'h0000_0000_FFFF_FFFE);
    drain(3, 1'b0, -1, 0, cyc);
    check("ovw_cycles", 64'(cyc), 64'd3);

    // Accumulate same data
    begin_tile(3, 1'b1, 1'b0);
    fill(3, 1'b0);
    check("acc_row0_col0", 64'(out_col0), 64'd10);
    check("acc_row0_col1", 64'(out_col1), 64'h0000_0000_FFFF_FFFC);
    drain(3, 1'b0, -1, 0, cyc);

    // Backpressure on row 1
    rand_data();
    begin_tile(3, 1'b0, 1'b0);
    fill(3, 1'b0);
    drain(3, 1'b0, 1, 4, cyc);
    check("bp_cycles", 64'(cyc), 64'd7);

    // Drop in IDLE, start ignored in DRAIN, drop in DRAIN
    valid_in = 1'b1; in_col0 = 16'h7777; in_col1 = 16'h1111;
    @(negedge clk);
    valid_in = 1'b0;
    check("drop_idle", 64'(drop_err), 64'd1);
    rand_data();
    begin_tile(2, 1'b1, 1'b0);
    fill(2, 1'b1);
    start = 1'b1; acc_mode = 1'b0; rows = CNT_W'(1);
    @(negedge clk);
    start = 1'b0;
    check("ign_start_valid", 64'(out_valid), 64'd1);
    check("ign_start_drop", 64'(drop_err), 64'd0);
    valid_in = 1'b1; in_col0 = 16'h1234; in_col1 = 16'h4321;
    @(negedge clk);
    valid_in = 1'b0;
    check("drop_drain", 64'(drop_err), 64'd1);
    drain(2, 1'b1, -1, 0, cyc);

    // valid_in coincident with an accepted start
    rand_data();
    begin_tile(4, 1'b1, 1'b1);
    fill(4, 1'b1);
    drain(4, 1'b1, -1, 0, cyc);

    // Randomized tiles including N=1 and out-of-range row counts
    for (int t = 0; t < 8; t++) begin
      r = (t == 0) ? 1 : (t == 1) ? 0 : (t == 2) ? 12 : int'($urandom_range(1, DEPTH));
      rand_data();
      begin_tile(r, 1'($urandom_range(0, 1)), 1'b0);
      fill(tile_n, 1'b1);
      drain(tile_n, 1'b1, -1, 0, cyc);
      if (tile_n == 1) check("n1_cycles_min", 64'(cyc >= 1), 64'd1);
    end

    // Reset mid-FILL
    rand_data();
    begin_tile(4, 1'b0, 1'b0);
    fill(2, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    model_clear();
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_done", 64'(done), 64'd0);
    end
    reset = 1'b0;
    rand_data();
    begin_tile(4, 1'b0, 1'b0);
    fill(4, 1'b1);
    drain(4, 1'b1, -1, 0, cyc);
    rand_data();
    begin_tile(6, 1'b1, 1'b0);
    fill(6, 1'b0);
    drain(6, 1'b1, -1, 0, cyc);

    // Overflow boundary on the narrow instance
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    st0[0] = 16'h7FF8; st1[0] = 16'h8000;
    begin_tile(1, 1'b0, 1'b0);
    fill(1, 1'b0);
    drain(1, 1'b0, -1, 0, cyc);
    begin_tile(1, 1'b1, 1'b0);
    fill(1, 1'b0);
    check("s_pre_col0", 64'(s_out_col0), 64'h0FFF0);
    check("s_pre_col1", 64'(s_out_col1), 64'h10000);
    drain(1, 1'b0, -1, 0, cyc);
    st0[0] = 16'h0020; st1[0] = 16'hFFFF;
    begin_tile(1, 1'b1, 1'b0);
    fill(1, 1'b0);
    check("s_valid", 64'(s_out_valid), 64'd1);
    check("s_busy", 64'(s_busy), 64'd1);
    check("s_done", 64'(s_done), 64'd0);
    check("s_drop", 64'(s_drop_err), 64'd0);
`ifdef ACCUM_BUFFER_SAT_EN
    check("s_sat_col0", 64'(s_out_col0), 64'h0FFFF);
    check("s_sat_col1", 64'(s_out_col1), 64'h10000);
    check("s_sat_flag", 64'(s_sat_flag), 64'd1);
    check("sat_flag_wide", 64'(sat_flag), 64'd0);
`else
    check("s_wrap_col0", 64'(s_out_col0), 64'h10010);
    check("s_wrap_col1", 64'(s_out_col1), 64'h0FFFF);
`endif
    drain(1, 1'b0, -1, 0, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accumulator_buffer.md
Name: accumulator_buffer

Overview:
- Sits directly downstream of the column-alignment stage and consumes its aligned valid/col0/col1 stream.
- Stores one tile's result rows in a DEPTH-row, 2-column register-file accumulator.
- Each row either overwrites its entry or adds to it, which supports K-dimension tiling.
- Once a tile's rows have been collected, drains them to the next consumer (activation/writeback) over a valid/ready handshake.

Parameters:
- DEPTH, 8, number of result rows held (2..64).
- ACC_W, 32, accumulator width per column in bits; must be at least 17.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  aligned row valid from the alignment stage.
- in_col0  input  16  aligned column-0 partial sum, signed.
- in_col1  input  16  aligned column-1 partial sum, signed.
- start  input  1  single-cycle pulse that begins a tile; sampled only in IDLE.
- acc_mode  input  1  sampled with start; 1 = add to stored row, 0 = overwrite.
- rows  input  $clog2(DEPTH+1)  number of rows in the tile, sampled with start; 0 or a value above DEPTH is treated as DEPTH.
- busy  output  1  high in FILL and DRAIN.
- done  output  1  one-cycle pulse after the last row has drained.
- out_valid  output  1  drain data valid.
- out_ready  input  1  downstream ready.
- out_col0  output  ACC_W  drained column-0 accumulator, signed.
- out_col1  output  ACC_W  drained column-1 accumulator, signed.
- drop_err  output  1  sticky flag; set when valid_in arrives outside FILL; cleared by an accepted start.

Behaviour:
- Reset is asynchronous and active-high:
  - state goes to IDLE; wr_ptr, rd_ptr and all memory entries go to 0.
  - busy, done, out_valid and drop_err are 0; out_col0 and out_col1 are 0.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - start=1 moves to FILL at the next edge.
  - That edge latches acc_mode and the effective row count N, sets wr_ptr=0 and clears drop_err.
- FILL:
  - Each cycle with valid_in=1 writes row wr_ptr.
  - Written value per column: sign-extend the 16-bit input to ACC_W, then store either mem+ext (acc_mode=1) or ext (acc_mode=0).
  - wr_ptr increments after each write. The write with wr_ptr=N-1 moves to DRAIN at the same edge and sets rd_ptr=0.
  - Gaps in valid_in are allowed; FILL waits with no timeout.
- DRAIN:
  - out_valid=1; out_col0 and out_col1 show mem[rd_ptr] combinationally from the flops.
  - A row written at the final FILL edge is visible on the first DRAIN cycle.
  - Data holds stable while out_valid=1 and out_ready=0.
  - A transfer occurs when out_valid and out_ready are both 1; rd_ptr then increments.
  - The transfer at rd_ptr=N-1 moves to IDLE; done=1 for exactly the following cycle.
  - Memory contents are retained after draining so the next acc_mode=1 tile accumulates onto them.
- Latency: the first out_valid occurs 1 cycle after the edge that writes row N-1. Full throughput is 1 row per cycle when out_ready is held high.
- Arithmetic: without the optional feature, addition is two's-complement and wraps modulo 2^ACC_W.
- Boundary conditions:
  - start outside IDLE is ignored and does not set drop_err.
  - valid_in in IDLE or DRAIN: data is discarded, memory is unchanged, drop_err is set.
  - valid_in on the same cycle as an accepted start: discarded, drop_err set. The clear from start takes priority only for that start edge, so drop_err reads 1 afterwards.
  - Reset asserted mid-FILL or mid-DRAIN aborts immediately; no done pulse is produced.
  - N=1 is legal: a single write, then a single drain beat.

Optional Feature:
- Macro: ACCUM_BUFFER_SAT_EN.
- When defined: accumulation saturates to the signed ACC_W range, i.e. max 2^(ACC_W-1)-1 and min -2^(ACC_W-1). Overflow is detected from the operand signs versus the result sign. An extra sticky output sat_flag (1 bit) is added; it resets to 0, is cleared by an accepted start, and is set on any saturating write.
- When undefined: wrapping arithmetic as described above, and no sat_flag port.

Test Plan:
- Overwrite tile: reset, start with rows=3 and acc_mode=0, stream (5,-2), (7,4), (-1,0) with out_ready=1.
  - Response: out_valid rises 1 cycle after the third write; outputs are (5,-2), (7,4), (-1,0) sign-extended to 32 bits; done pulses 1 cycle after the third beat.
- Accumulate: repeat the previous tile with acc_mode=1 and the same data.
  - Response: drains (10,-4), (14,8), (-2,0).
- Backpressure: during DRAIN, hold out_ready=0 for 4 cycles on row 1.
  - Response: out_col0/out_col1 stay stable at row 1; rd_ptr does not advance; total drain time grows by 4 cycles.
- Drop and ignore: pulse valid_in in IDLE, and pulse start during DRAIN.
  - Response: drop_err=1; memory is unchanged; state is unaffected by the start; the next accepted start clears drop_err.
- Reset mid-FILL: assert reset after 2 of 4 rows have been written.
  - Response: busy=0 and out_valid=0 immediately (asynchronous); no done pulse; a following overwrite tile drains correct data.
- Wrap or saturation: acc_mode=1 with a row preloaded at 0x7FFFFFF0, add 0x0020.
  - Without the macro: result 0x80000010.
  - With ACCUM_BUFFER_SAT_EN: result 0x7FFFFFFF and sat_flag=1.
